// File: rtl/pi_shift_in_pkg.sv
// ---------------------------------------------------------------------------
// pi_shift_in_pkg
// Shared definitions for the Pi serial shift-in block: target select codes,
// byte and counter widths, and the FSM state encoding.
// ---------------------------------------------------------------------------
package pi_shift_in_pkg;

  localparam int BYTE_W = 8;
  // Counter is wide enough to count past a full byte so overruns are visible.
  localparam int CNT_W  = 4;

  localparam logic [1:0] SEL_RD = 2'd0;
  localparam logic [1:0] SEL_RC = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2,
    ST_OVER  = 2'd3
  } piState_t;

  // Only RD and RC are real targets; the other two codes are reserved.
  function automatic logic isKnownSel(input logic [1:0] sel);
    return (sel == SEL_RD) || (sel == SEL_RC);
  endfunction

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk      - destination clock
//   reset_n  - asynchronous active-low reset, clears both flops
//   i_async  - asynchronous input bit
//   o_sync   - input bit resynchronized to clk
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pi_shift_in.sv
// ---------------------------------------------------------------------------
// pi_shift_in
// Receives bytes from the Pi over a three-wire serial link (shift clock, data,
// latch enable) plus a two-bit target select, and commits complete bytes to
// the RD or RC output register in the clk domain.
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   r_clk      - Pi shift clock (asynchronous)
//   r_din      - Pi serial data, MSB first
//   r_le       - Pi latch enable (asynchronous), rising edge commits
//   r_sel      - target select: 0 = RD, 1 = RC, 2/3 reserved
//   rd_out     - RD byte register
//   rc_out     - RC byte register
//   rd_strobe  - one-cycle pulse when rd_out updates
//   rc_strobe  - one-cycle pulse when rc_out updates
//   frame_err  - sticky flag: the last latch attempt was malformed
// ---------------------------------------------------------------------------
module pi_shift_in
  import pi_shift_in_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r_clk,
  input  logic              r_din,
  input  logic              r_le,
  input  logic [1:0]        r_sel,
  output logic [BYTE_W-1:0] rd_out,
  output logic [BYTE_W-1:0] rc_out,
  output logic              rd_strobe,
  output logic              rc_strobe,
  output logic              frame_err
);

  logic             w_clkSync;
  logic             w_dinSync;
  logic             w_leSync;
  logic [1:0]       w_selSync;

  logic             r_clkPrev;
  logic             r_lePrev;
  logic             r_clkRise;
  logic             r_leRise;

  piState_t         r_state;
  piState_t         w_nextState;
  logic [CNT_W-1:0] r_bitCount;
  logic [BYTE_W-1:0] r_shift;

  logic             w_commitRd;
  logic             w_commitRc;
  logic             w_errSet;
  logic             w_errClr;

  sync2 u_syncClk  (.clk(clk), .reset_n(reset_n), .i_async(r_clk),    .o_sync(w_clkSync));
  sync2 u_syncDin  (.clk(clk), .reset_n(reset_n), .i_async(r_din),    .o_sync(w_dinSync));
  sync2 u_syncLe   (.clk(clk), .reset_n(reset_n), .i_async(r_le),     .o_sync(w_leSync));
  sync2 u_syncSel0 (.clk(clk), .reset_n(reset_n), .i_async(r_sel[0]), .o_sync(w_selSync[0]));
  sync2 u_syncSel1 (.clk(clk), .reset_n(reset_n), .i_async(r_sel[1]), .o_sync(w_selSync[1]));

  // Edge detectors: the rise pulse is registered, so each pulse lasts exactly
  // one clk cycle and the commit lands one edge after detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clkPrev <= 1'b0;
      r_lePrev  <= 1'b0;
      r_clkRise <= 1'b0;
      r_leRise  <= 1'b0;
    end else begin
      r_clkPrev <= w_clkSync;
      r_lePrev  <= w_leSync;
      r_clkRise <= w_clkSync & ~r_clkPrev;
      r_leRise  <= w_leSync & ~r_lePrev;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Latch edges win over shift edges: a latch is judged on the state before
  // any coincident shift, and the coincident shift is thrown away. A clean
  // latch still commits in that case, but the collision is flagged as an error.
  always_comb begin
    w_nextState = r_state;
    w_commitRd  = 1'b0;
    w_commitRc  = 1'b0;
    w_errSet    = 1'b0;
    w_errClr    = 1'b0;
    if (r_leRise) begin
      w_nextState = ST_IDLE;
      if (r_state == ST_FULL && w_selSync == SEL_RD) begin
        w_commitRd = 1'b1;
      end else if (r_state == ST_FULL && w_selSync == SEL_RC) begin
        w_commitRc = 1'b1;
      end
      if (r_state == ST_FULL && isKnownSel(w_selSync) && !r_clkRise) begin
        w_errClr = 1'b1;
      end else begin
        w_errSet = 1'b1;
      end
    end else if (r_clkRise) begin
      case (r_state)
        ST_IDLE:  w_nextState = ST_SHIFT;
        ST_SHIFT: begin
          if (r_bitCount == CNT_W'(BYTE_W - 1)) begin
            w_nextState = ST_FULL;
          end
        end
        ST_FULL:  w_nextState = ST_OVER;
        ST_OVER:  w_nextState = ST_OVER;
        default:  w_nextState = ST_IDLE;
      endcase
    end
  end

  // Shift register and bit counter; the counter saturates so long overruns
  // can never wrap back into looking like a valid byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_bitCount <= '0;
    end else if (r_leRise) begin
      r_shift    <= '0;
      r_bitCount <= '0;
    end else if (r_clkRise) begin
      r_shift <= {r_shift[BYTE_W-2:0], w_dinSync};
      if (r_bitCount != {CNT_W{1'b1}}) begin
        r_bitCount <= r_bitCount + 1'b1;
      end
    end
  end

  // Output registers: byte and strobe are loaded on the same edge, and the
  // bytes hold between commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_out    <= '0;
      rc_out    <= '0;
      rd_strobe <= 1'b0;
      rc_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rd_strobe <= w_commitRd;
      rc_strobe <= w_commitRc;
      if (w_commitRd) begin
        rd_out <= r_shift;
      end
      if (w_commitRc) begin
        rc_out <= r_shift;
      end
      if (w_errSet) begin
        frame_err <= 1'b1;
      end else if (w_errClr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pi_shift_in.sv
// ---------------------------------------------------------------------------
// tb_pi_shift_in
// Self-checking bench for pi_shift_in. Pi-side pins are driven slowly relative
// to clk; a reference model keeps the list of bits shifted since the last
// latch and decides each latch outcome from that list alone.
// ---------------------------------------------------------------------------
module tb_pi_shift_in;

  logic       clk;
  logic       reset_n;
  logic       r_clk;
  logic       r_din;
  logic       r_le;
  logic [1:0] r_sel;
  logic [7:0] rd_out;
  logic [7:0] rc_out;
  logic       rd_strobe;
  logic       rc_strobe;
  logic       frame_err;

  int testsRun  = 0;
  int failCount = 0;

  int rdStbCnt    = 0;
  int rcStbCnt    = 0;
  int bothHighCnt = 0;

  bit         mBits[$];
  logic [7:0] mRd;
  logic [7:0] mRc;
  logic       mErr;

  pi_shift_in dut (
    .clk(clk), .reset_n(reset_n), .r_clk(r_clk), .r_din(r_din), .r_le(r_le),
    .r_sel(r_sel), .rd_out(rd_out), .rc_out(rc_out), .rd_strobe(rd_strobe),
    .rc_strobe(rc_strobe), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe-high cycles, sampled away from the active edge.
  always @(negedge clk) begin
    if (rd_strobe === 1'b1) rdStbCnt++;
    if (rc_strobe === 1'b1) rcStbCnt++;
    if (rd_strobe === 1'b1 && rc_strobe === 1'b1) bothHighCnt++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic modelReset();
    mBits.delete();
    mRd  = 8'h00;
    mRc  = 8'h00;
    mErr = 1'b0;
  endtask

  // A latch succeeds only with exactly eight bits and a real target; a
  // coincident shift edge still lets it commit but flags the collision.
  task automatic modelLatch(input logic [1:0] sel, input bit simult,
                            output int expRdStb, output int expRcStb);
    int v;
    expRdStb = 0;
    expRcStb = 0;
    if (mBits.size() == 8 && sel < 2) begin
      v = 0;
      foreach (mBits[i]) v = v * 2 + int'(mBits[i]);
      if (sel == 2'd0) begin
        mRd = v[7:0];
        expRdStb = 1;
      end else begin
        mRc = v[7:0];
        expRcStb = 1;
      end
      mErr = simult;
    end else begin
      mErr = 1'b1;
    end
    mBits.delete();
  endtask

  task automatic shiftBit(input bit b);
    @(negedge clk);
    r_din = b;
    waitCycles(3);
    r_clk = 1'b1;
    waitCycles(4);
    r_clk = 1'b0;
    waitCycles(3);
    mBits.push_back(b);
  endtask

  task automatic shiftBits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shiftBit(v[i]);
  endtask

  task automatic pulseLatch(input logic [1:0] sel);
    @(negedge clk);
    r_sel = sel;
    waitCycles(3);
    r_le = 1'b1;
    waitCycles(4);
    r_le = 1'b0;
    waitCycles(4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    r_clk = 1'b0; r_din = 1'b0; r_le = 1'b0; r_sel = 2'd0;
    modelReset();
    waitCycles(3);
    testsRun++;
    if ({rd_out, rc_out, rd_strobe, rc_strobe, frame_err} !== 19'h0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got rd=%h rc=%h stb=%b%b err=%b, expected all zero",
               rd_out, rc_out, rd_strobe, rc_strobe, frame_err);
    end
    reset_n = 1'b1;
    waitCycles(2);
  endtask

  task automatic test_rd_byte();
    int s0, c0, eR, eC;
    shiftBits(16'h00A5, 8);
    s0 = rdStbCnt; c0 = rcStbCnt;
    pulseLatch(2'd0);
    modelLatch(2'd0, 0, eR, eC);
    testsRun++;
    if (rd_out !== 8'hA5) begin
      failCount++; $display("[TB] FAIL rd_A5_value: got %h expected a5", rd_out);
    end
    testsRun++;
    if ((rdStbCnt - s0) !== 1 || (rcStbCnt - c0) !== 0) begin
      failCount++;
      $display("[TB] FAIL rd_A5_strobe: got rd=%0d rc=%0d cycles expected 1/0", rdStbCnt - s0, rcStbCnt - c0);
    end
    testsRun++;
    if (rc_out !== 8'h00 || frame_err !== 1'b0) begin
      failCount++; $display("[TB] FAIL rd_A5_others: got rc=%h err=%b expected 00/0", rc_out, frame_err);
    end
  endtask

  task automatic test_rc_then_short();
    int s0, c0, eR, eC;
    shiftBits(16'h003C, 8);
    c0 = rcStbCnt;
    pulseLatch(2'd1);
    modelLatch(2'd1, 0, eR, eC);
    testsRun++;
    if (rc_out !== 8'h3C || (rcStbCnt - c0) !== 1 || frame_err !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rc_3C: got rc=%h stb=%0d err=%b expected 3c/1/0", rc_out, rcStbCnt - c0, frame_err);
    end
    shiftBits(16'h0015, 5);
    s0 = rdStbCnt; c0 = rcStbCnt;
    pulseLatch(2'd1);
    modelLatch(2'd1, 0, eR, eC);
    testsRun++;
    if (frame_err !== 1'b1 || rc_out !== 8'h3C || (rcStbCnt - c0) !== 0 || (rdStbCnt - s0) !== 0) begin
      failCount++;
      $display("[TB] FAIL short_frame: got err=%b rc=%h stb=%0d/%0d expected 1/3c/0/0",
               frame_err, rc_out, rdStbCnt - s0, rcStbCnt - c0);
    end
  endtask

  task automatic test_overflow();
    int s0, eR, eC;
    shiftBits(16'h0101, 9);
    s0 = rdStbCnt;
    pulseLatch(2'd0);
    modelLatch(2'd0, 0, eR, eC);
    testsRun++;
    if (frame_err !== 1'b1 || rd_out !== 8'hA5 || (rdStbCnt - s0) !== 0) begin
      failCount++;
      $display("[TB] FAIL overflow_9bit: got err=%b rd=%h stb=%0d expected 1/a5/0", frame_err, rd_out, rdStbCnt - s0);
    end
    shiftBits(16'h00FF, 8);
    s0 = rdStbCnt;
    pulseLatch(2'd0);
    modelLatch(2'd0, 0, eR, eC);
    testsRun++;
    if (rd_out !== 8'hFF || frame_err !== 1'b0 || (rdStbCnt - s0) !== 1) begin
      failCount++;
      $display("[TB] FAIL recover_FF: got rd=%h err=%b stb=%0d expected ff/0/1", rd_out, frame_err, rdStbCnt - s0);
    end
  endtask

  task automatic test_reserved_sel();
    int s0, c0, eR, eC;
    shiftBits(16'h0012, 8);
    s0 = rdStbCnt; c0 = rcStbCnt;
    pulseLatch(2'd2);
    modelLatch(2'd2, 0, eR, eC);
    testsRun++;
    if ((rdStbCnt - s0) !== 0 || (rcStbCnt - c0) !== 0 || rd_out !== 8'hFF ||
        rc_out !== 8'h3C || frame_err !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reserved_sel: got rd=%h rc=%h err=%b stb=%0d/%0d expected ff/3c/1/0/0",
               rd_out, rc_out, frame_err, rdStbCnt - s0, rcStbCnt - c0);
    end
  endtask

  task automatic test_latency();
    int lat, s0, eR, eC;
    shiftBits(16'h005A, 8);
    @(negedge clk);
    r_sel = 2'd0;
    waitCycles(3);
    s0 = rdStbCnt;
    r_le = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (rd_strobe === 1'b1 && lat == 0) lat = k;
    end
    @(negedge clk);
    r_le = 1'b0;
    waitCycles(4);
    modelLatch(2'd0, 0, eR, eC);
    testsRun++;
    if (lat !== 4) begin
      failCount++; $display("[TB] FAIL latch_latency: got %0d edges expected 4", lat);
    end
    testsRun++;
    if (rd_out !== 8'h5A || (rdStbCnt - s0) !== 1) begin
      failCount++; $display("[TB] FAIL latency_value: got rd=%h stb=%0d expected 5a/1", rd_out, rdStbCnt - s0);
    end
  endtask

  task automatic test_reset_mid_shift();
    int eR, eC;
    shiftBits(16'h000B, 4);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    testsRun++;
    if ({rd_out, rc_out, rd_strobe, rc_strobe, frame_err} !== 19'h0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got rd=%h rc=%h stb=%b%b err=%b expected all zero",
               rd_out, rc_out, rd_strobe, rc_strobe, frame_err);
    end
    modelReset();
    waitCycles(3);
    reset_n = 1'b1;
    waitCycles(2);
    shiftBits(16'h0081, 8);
    pulseLatch(2'd0);
    modelLatch(2'd0, 0, eR, eC);
    testsRun++;
    if (rd_out !== 8'h81 || rc_out !== 8'h00 || frame_err !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL after_reset_81: got rd=%h rc=%h err=%b expected 81/00/0", rd_out, rc_out, frame_err);
    end
  endtask

  task automatic test_simultaneous();
    int s0, c0, eR, eC;
    shiftBits(16'h00C3, 8);
    @(negedge clk);
    r_sel = 2'd0;
    waitCycles(3);
    s0 = rdStbCnt;
    r_din = 1'b1;
    r_clk = 1'b1;
    r_le  = 1'b1;
    waitCycles(5);
    r_clk = 1'b0;
    r_le  = 1'b0;
    waitCycles(4);
    modelLatch(2'd0, 1, eR, eC);
    testsRun++;
    if (rd_out !== 8'hC3 || (rdStbCnt - s0) !== eR || frame_err !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL simultaneous_edge: got rd=%h stb=%0d err=%b expected c3/%0d/1",
               rd_out, rdStbCnt - s0, frame_err, eR);
    end
    shiftBits(16'h00E7, 8);
    c0 = rcStbCnt;
    pulseLatch(2'd1);
    modelLatch(2'd1, 0, eR, eC);
    testsRun++;
    if (rc_out !== 8'hE7 || frame_err !== 1'b0 || (rcStbCnt - c0) !== 1) begin
      failCount++;
      $display("[TB] FAIL post_collision_byte: got rc=%h err=%b stb=%0d expected e7/0/1", rc_out, frame_err, rcStbCnt - c0);
    end
  endtask

  task automatic test_random();
    int len, s0, c0, eR, eC, pick;
    logic [1:0] sel;
    for (int it = 0; it < 24; it++) begin
      pick = $urandom_range(0, 9);
      len  = (pick < 6) ? 8 : $urandom_range(0, 11);
      pick = $urandom_range(0, 5);
      sel  = (pick < 4) ? 2'(pick % 2) : 2'($urandom_range(2, 3));
      for (int b = 0; b < len; b++) shiftBit(bit'($urandom_range(0, 1)));
      s0 = rdStbCnt; c0 = rcStbCnt;
      pulseLatch(sel);
      modelLatch(sel, 0, eR, eC);
      testsRun++;
      if (rd_out !== mRd || rc_out !== mRc || frame_err !== mErr ||
          (rdStbCnt - s0) !== eR || (rcStbCnt - c0) !== eC) begin
        failCount++;
        $display("[TB] FAIL random_%0d len=%0d sel=%0d: got rd=%h rc=%h err=%b stb=%0d/%0d expected %h/%h/%b/%0d/%0d",
                 it, len, sel, rd_out, rc_out, frame_err, rdStbCnt - s0, rcStbCnt - c0, mRd, mRc, mErr, eR, eC);
      end
    end
  endtask

  task automatic test_strobe_exclusive();
    testsRun++;
    if (bothHighCnt !== 0) begin
      failCount++; $display("[TB] FAIL strobe_exclusive: got %0d cycles both high expected 0", bothHighCnt);
    end
  endtask

  initial begin
    test_reset();
    test_rd_byte();
    test_rc_then_short();
    test_overflow();
    test_reserved_sel();
    test_latency();
    test_reset_mid_shift();
    test_simultaneous();
    test_random();
    test_strobe_exclusive();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
